// File: rtl/arg_feeder_if.sv
// Handshake bundle between a producer, the argument feeder and the downstream accumulator.
// The producer/bench drives through the master modport and the feeder uses the slave modport.
interface arg_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_arg;
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic [WIDTH-1:0] out_arg;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_out;

  modport master (
    output in_arg, in_valid, hold,
    input  in_ready, out_arg, out_valid, count, sum_out
  );

  modport slave (
    input  in_arg, in_valid, hold,
    output in_ready, out_arg, out_valid, count, sum_out
  );
endinterface

// File: rtl/arg_feeder.sv
// DEPTH-entry FIFO issuing one argument per cycle (zero when idle) to an accumulator.
// Optional shadow running sum of issued arguments: define ARG_FEEDER_SHADOW_SUM_EN.
module arg_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  arg_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_arg_q, out_arg_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  // Ready depends only on registered occupancy, so a pop never frees a slot the same edge.
  assign bus.in_ready = (count_q != CW'(DEPTH));

  always_comb begin
    push        = bus.in_valid && (count_q != CW'(DEPTH));
    pop         = (count_q != '0) && !bus.hold;
    head        = mem_q[rd_ptr_q];
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    out_arg_d   = pop ? head : '0;
    out_valid_d = pop;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_arg_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_arg_q   <= out_arg_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= bus.in_arg;
    end
  end

  assign bus.out_arg   = out_arg_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;

`ifdef ARG_FEEDER_SHADOW_SUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q + out_arg_d;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.sum_out = sum_q;
`else
  assign bus.sum_out = '0;
`endif
endmodule

// File: tb/tb_arg_feeder.sv
// Scoreboard bench for arg_feeder: directed pushes queue their expected issue order,
// and a negedge monitor checks every issued argument and the shadow sum.
module tb_arg_feeder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef ARG_FEEDER_SHADOW_SUM_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_sum = '0;

  arg_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  arg_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    exp_q.delete();
    exp_sum = '0;
    rst_n = 1'b1;
  endtask

  // Monitor: every issued argument must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        if (bus.out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'(bus.out_arg), 32'hFFFF_FFFF);
          end else begin
            logic [WIDTH-1:0] v;
            v = exp_q.pop_front();
            $display("[TB] issue %0d (expected %0d)", bus.out_arg, v);
            check("issue_arg", 32'(bus.out_arg), 32'(v));
            if (SHADOW) exp_sum = exp_sum + v;
          end
        end else begin
          check("idle_arg_zero", 32'(bus.out_arg), 32'd0);
        end
        check("sum_out", 32'(bus.sum_out), 32'(exp_sum));
      end
    end
  end

  initial begin
    bus.in_arg   = '0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    step();
    do_reset();
    started = 1'b1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_arg", 32'(bus.out_arg), 32'd0);
    check("rst_sum", 32'(bus.sum_out), 32'd0);

    // Two-edge latency: 72 then 36
    exp_q.push_back(8'd72);
    exp_q.push_back(8'd36);
    bus.in_valid = 1'b1; bus.in_arg = 8'd72;
    step();
    check("lat_no_issue_e1", 32'(bus.out_valid), 32'd0);
    check("lat_count_e1", 32'(bus.count), 32'd1);
    bus.in_arg = 8'd36;
    step();
    check("lat_arg_e2", 32'(bus.out_arg), 32'd72);
    check("lat_valid_e2", 32'(bus.out_valid), 32'd1);
    check("lat_sum_e2", 32'(bus.sum_out), SHADOW ? 32'd72 : 32'd0);
    bus.in_valid = 1'b0;
    step();
    check("lat_arg_e3", 32'(bus.out_arg), 32'd36);
    check("lat_sum_e3", 32'(bus.sum_out), SHADOW ? 32'd108 : 32'd0);
    step();
    check("lat_idle_valid", 32'(bus.out_valid), 32'd0);
    check("lat_idle_arg", 32'(bus.out_arg), 32'd0);

    // Fill under hold, reject extra pushes, then drain
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    bus.hold = 1'b1; bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_arg = 8'(i);
      step();
    end
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_arg = 8'd5;
    step();
    check("full_reject_count", 32'(bus.count), 32'd4);
    bus.hold = 1'b0; bus.in_arg = 8'd99;
    step();
    check("full_pop_no_bypass", 32'(bus.count), 32'd3);
    check("full_ready_after_pop", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("drain_count", 32'(bus.count), 32'd0);
    step();
    check("drain_idle", 32'(bus.out_valid), 32'd0);

    // Steady push+pop at count=2 across pointer wrap
    exp_q.push_back(8'd100);
    exp_q.push_back(8'd101);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    bus.hold = 1'b1; bus.in_valid = 1'b1;
    bus.in_arg = 8'd100; step();
    bus.in_arg = 8'd101; step();
    bus.hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_arg = 8'(i);
      step();
      check($sformatf("steady_count_%0d", i), 32'(bus.count), 32'd2);
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    check("steady_drain_count", 32'(bus.count), 32'd0);
    @(negedge clock);
    check("steady_all_issued", 32'(exp_q.size()), 32'd0);
    step();

    // Shadow sum wraps mod 256: 200 then 44
    do_reset();
    exp_q.push_back(8'd200);
    exp_q.push_back(8'd100);
    bus.in_valid = 1'b1; bus.in_arg = 8'd200; step();
    bus.in_arg = 8'd100; step();
    check("wrap_sum_200", 32'(bus.sum_out), SHADOW ? 32'd200 : 32'd0);
    bus.in_valid = 1'b0;
    step();
    check("wrap_sum_44", 32'(bus.sum_out), SHADOW ? 32'd44 : 32'd0);

    // Reset mid-operation discards entries and ignores the concurrent push
    bus.hold = 1'b1; bus.in_valid = 1'b1;
    bus.in_arg = 8'd11; step();
    bus.in_arg = 8'd12; step();
    bus.in_arg = 8'd13; step();
    check("pre_rst_count", 32'(bus.count), 32'd3);
    rst_n = 1'b0; bus.hold = 1'b0; bus.in_arg = 8'd77;
    step();
    exp_q.delete();
    exp_sum = '0;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum", 32'(bus.sum_out), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    step();
    check("post_rst_no_issue", 32'(bus.out_valid), 32'd0);
    check("post_rst_count", 32'(bus.count), 32'd0);
    @(negedge clock);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arg_feeder.md
ARG_FEEDER -- requirements
Module: arg_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, argument bit width.
REQ-002 Parameter: DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 Port: clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
REQ-005 Port: in_arg  input  WIDTH  argument offered by producer.
REQ-006 Port: in_valid  input  1  in_arg holds a valid argument.
REQ-007 Port: in_ready  output  1  queue can accept in_arg this cycle.
REQ-008 Port: hold  input  1  suppresses issue to the downstream accumulator this cycle.
REQ-009 Port: out_arg  output  WIDTH  registered argument for downstream tock_arg input.
REQ-010 Port: out_valid  output  1  out_arg was issued on the last edge.
REQ-011 Port: count  output  clog2(DEPTH)+1  number of queued entries.
REQ-012 Port: sum_out  output  WIDTH  shadow running sum of issued arguments (see Configuration).

Function
REQ-013 Block SHALL be a DEPTH-entry FIFO feeding one argument per cycle into a downstream accumulator that adds its input every clock.
REQ-014 in_ready SHALL equal (count != DEPTH), derived from registered count only; no combinational path from in_valid or hold.
REQ-015 Push SHALL occur on an edge where in_valid && in_ready; in_arg written at write pointer, pointer advances mod DEPTH.
REQ-016 Pop SHALL occur on an edge where count != 0 and hold == 0; head copied to out_arg, out_valid set 1, read pointer advances mod DEPTH.
REQ-017 On an edge with no pop, out_arg SHALL be 0 and out_valid 0, so the downstream accumulator adds zero.
REQ-018 Pop eligibility SHALL use count before the edge; an entry pushed on edge k is first poppable on edge k+1 (2-edge minimum in-to-out latency).
REQ-019 count SHALL update as count + push - pop; push and pop on the same edge leave count unchanged.
REQ-020 When full, in_ready SHALL be 0 even if a pop occurs that edge; no bypass.
REQ-021 Empty queue with in_valid=1 SHALL push but not issue that edge; out_valid=0.
REQ-022 Entries SHALL issue in push order; no entry dropped or duplicated across pointer wrap.
REQ-023 hold SHALL not affect push acceptance.

Reset
REQ-024 rst_n=0 at an edge SHALL set count=0, both pointers=0, out_arg=0, out_valid=0, sum_out=0; in_ready=1 after that edge.
REQ-025 Reset mid-operation SHALL discard all queued entries; a push presented during reset SHALL be ignored.
REQ-026 Reset SHALL take priority over push, pop and hold.

Configuration
REQ-027 Macro ARG_FEEDER_SHADOW_SUM_EN defined: sum_out SHALL add each issued out_arg on the edge it issues, wrapping mod 2^WIDTH, matching the downstream accumulator one edge later.
REQ-028 Macro ARG_FEEDER_SHADOW_SUM_EN undefined: sum_out SHALL be constant 0 and no sum register SHALL exist; all other behaviour identical.

Verification
REQ-029 Reset, then push 72 then 36 on consecutive edges, hold=0 -> out_arg 72 after edge 2, 36 after edge 3, then 0 with out_valid=0; sum_out 72 then 108 (SHADOW_SUM_EN).
REQ-030 hold=1, push 1,2,3,4 -> count=4, in_ready=0, 5th in_valid ignored; release hold -> 1,2,3,4 issued on 4 consecutive edges, in_ready=1 after first pop.
REQ-031 Queue at count=2, simultaneous push and pop for 10 edges with values 0..9 -> count stays 2, outputs in order across pointer wrap.
REQ-032 SHADOW_SUM_EN: issue 200 then 100 -> sum_out 200 then 44 (mod-256 wrap).
REQ-033 count=3, assert rst_n=0 for one edge with in_valid=1 -> count=0, out_valid=0, sum_out=0; next edge pops nothing.
